// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit
// Moore control FSM that steps the shared multicycle datapath (one ALU, one
// memory port) through fetch, decode, execute, memory and writeback steps for
// R-type, addi, lw, sw and beq. Memory accesses use a ready handshake with a
// bounded wait. A retired-instruction counter and two sticky error flags
// (illegal opcode, memory timeout) are provided for debug.
// Optional feature macro: JUMP_EN -- when defined, opcode 000010 is executed
// as a jump through state 11; when undefined it is treated as illegal.
module multicycle_ctrl_unit #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             Clk_1b,
   input  logic             Reset_n_1b,
   input  logic [5:0]       Opcode_6b,
   input  logic             Zero_1b,
   input  logic             MemReady_1b,
   output logic             PCWrite_1b,
   output logic             PCWriteCond_1b,
   output logic             PCEn_1b,
   output logic             IorD_1b,
   output logic             MemRead_1b,
   output logic             MemWrite_1b,
   output logic             IRWrite_1b,
   output logic             MemtoReg_1b,
   output logic             RegDst_1b,
   output logic             RegWrite_1b,
   output logic             ALUSrcA_1b,
   output logic [1:0]       ALUSrcB_2b,
   output logic [1:0]       ALUOp_2b,
   output logic [1:0]       PCSource_2b,
   output logic [3:0]       State_4b,
   output logic             IllegalOp_1b,
   output logic             MemTimeout_1b,
   output logic [CNT_W-1:0] InstrCount
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
   } state_e;

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
`ifdef JUMP_EN
   localparam logic [5:0] OpJ     = 6'b000010;
`endif

   // The wait counter starts at 0 in the first cycle of an access, so the
   // last cycle allowed to see MemReady is the one where it equals
   // MEM_TIMEOUT-1; without ready there the access is abandoned.
   localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [7:0]       waitCnt_q, waitCnt_d;
   logic [CNT_W-1:0] instrCnt_q;
   logic             illegal_q;
   logic             timeout_q;
   logic             illegalSet;
   logic             timeoutSet;
   logic             retire;
   logic             memWait;

   // Next-state decode, wait counting and detection of retire/error events.
   always_comb begin
      state_d    = state_q;
      waitCnt_d  = 8'd0;
      illegalSet = 1'b0;
      timeoutSet = 1'b0;
      retire     = 1'b0;
      memWait    = 1'b0;
      case (state_q)
         FETCH: begin
            memWait = 1'b1;
            if (MemReady_1b) state_d = DECODE;
         end
         DECODE: begin
            case (Opcode_6b)
               OpRType:    state_d = EXEC;
               OpLw, OpSw: state_d = MEMADR;
               OpBeq:      state_d = BRANCH;
               OpAddi:     state_d = ADDIEX;
`ifdef JUMP_EN
               OpJ:        state_d = JUMP;
`endif
               default: begin
                  state_d    = FETCH;
                  illegalSet = 1'b1;
               end
            endcase
         end
         MEMADR: state_d = (Opcode_6b == OpLw) ? MEMRD : MEMWR;
         MEMRD: begin
            memWait = 1'b1;
            if (MemReady_1b) state_d = MEMWB;
         end
         MEMWB: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         MEMWR: begin
            memWait = 1'b1;
            if (MemReady_1b) begin
               state_d = FETCH;
               retire  = 1'b1;
            end
         end
         EXEC:   state_d = ALUWB;
         ALUWB: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         BRANCH: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         ADDIEX: state_d = ADDIWB;
         ADDIWB: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
`ifdef JUMP_EN
         JUMP: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
`endif
         default: state_d = FETCH;
      endcase
      if (memWait && !MemReady_1b) begin
         if (waitCnt_q == WaitLast) begin
            timeoutSet = 1'b1;
            state_d    = FETCH;
         end else begin
            waitCnt_d = waitCnt_q + 8'd1;
         end
      end
   end

   // State, wait counter, retire counter and sticky flags; reset abandons any access.
   always_ff @(posedge Clk_1b or negedge Reset_n_1b) begin
      if (!Reset_n_1b) begin
         state_q    <= FETCH;
         waitCnt_q  <= 8'd0;
         instrCnt_q <= '0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         if (retire)     instrCnt_q <= instrCnt_q + CNT_W'(1);
         if (illegalSet) illegal_q  <= 1'b1;
         if (timeoutSet) timeout_q  <= 1'b1;
      end
   end

   // Moore control decode; only the fetch handshake strobes follow MemReady.
   always_comb begin
      PCWrite_1b     = 1'b0;
      PCWriteCond_1b = 1'b0;
      IorD_1b        = 1'b0;
      MemRead_1b     = 1'b0;
      MemWrite_1b    = 1'b0;
      IRWrite_1b     = 1'b0;
      MemtoReg_1b    = 1'b0;
      RegDst_1b      = 1'b0;
      RegWrite_1b    = 1'b0;
      ALUSrcA_1b     = 1'b0;
      ALUSrcB_2b     = 2'b00;
      ALUOp_2b       = 2'b00;
      PCSource_2b    = 2'b00;
      case (state_q)
         FETCH: begin
            MemRead_1b = 1'b1;
            ALUSrcB_2b = 2'b01;
            IRWrite_1b = MemReady_1b;
            PCWrite_1b = MemReady_1b;
         end
         DECODE: ALUSrcB_2b = 2'b11;
         MEMADR: begin
            ALUSrcA_1b = 1'b1;
            ALUSrcB_2b = 2'b10;
         end
         MEMRD: begin
            MemRead_1b = 1'b1;
            IorD_1b    = 1'b1;
         end
         MEMWB: begin
            RegWrite_1b = 1'b1;
            MemtoReg_1b = 1'b1;
         end
         MEMWR: begin
            MemWrite_1b = 1'b1;
            IorD_1b     = 1'b1;
         end
         EXEC: begin
            ALUSrcA_1b = 1'b1;
            ALUOp_2b   = 2'b10;
         end
         ALUWB: begin
            RegDst_1b   = 1'b1;
            RegWrite_1b = 1'b1;
         end
         BRANCH: begin
            ALUSrcA_1b     = 1'b1;
            ALUOp_2b       = 2'b01;
            PCWriteCond_1b = 1'b1;
            PCSource_2b    = 2'b01;
         end
         ADDIEX: begin
            ALUSrcA_1b = 1'b1;
            ALUSrcB_2b = 2'b10;
         end
         ADDIWB: RegWrite_1b = 1'b1;
`ifdef JUMP_EN
         JUMP: begin
            PCWrite_1b  = 1'b1;
            PCSource_2b = 2'b10;
         end
`endif
         default: ;
      endcase
   end

   assign PCEn_1b       = PCWrite_1b | (PCWriteCond_1b & Zero_1b);
   assign State_4b      = state_q;
   assign IllegalOp_1b  = illegal_q;
   assign MemTimeout_1b = timeout_q;
   assign InstrCount    = instrCnt_q;

endmodule

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
Moore-style control FSM that sequences the shared execution datapath (main control decode, ALU control, ALU, branch adder) over multiple cycles for R-type, addi, lw, sw and beq. One ALU and one memory port are reused across the fetch, decode, execute, memory and writeback steps. The memory handshake is a ready signal with a timeout. A retired-instruction counter and sticky error flags support debug.

Parameters:
CNT_W, 16, width of retired-instruction counter
MEM_TIMEOUT, 15, max wait cycles for MemReady_1b before abandoning an access (1..255)

Ports:
Clk_1b  in  1  clock, rising edge
Reset_n_1b  in  1  asynchronous active-low reset
Opcode_6b  in  6  IR opcode field, valid from DECODE onward
Zero_1b  in  1  ALU zero flag
MemReady_1b  in  1  memory access complete this cycle
PCWrite_1b  out  1  unconditional PC load
PCWriteCond_1b  out  1  PC load if Zero_1b
PCEn_1b  out  1  PCWrite_1b | (PCWriteCond_1b & Zero_1b)
IorD_1b  out  1  0 = PC address, 1 = ALUOut address
MemRead_1b  out  1  memory read request
MemWrite_1b  out  1  memory write request
IRWrite_1b  out  1  IR load
MemtoReg_1b  out  1  writeback source is MDR
RegDst_1b  out  1  1 = rd, 0 = rt
RegWrite_1b  out  1  register file write
ALUSrcA_1b  out  1  0 = PC, 1 = BusA
ALUSrcB_2b  out  2  00 = BusB, 01 = 4, 10 = SExtn, 11 = SExtn<<2
ALUOp_2b  out  2  to ALU control: 00 = add, 01 = sub, 10 = funct
PCSource_2b  out  2  00 = ALU, 01 = ALUOut (branch target), 10 = jump
State_4b  out  4  current state encoding
IllegalOp_1b  out  1  sticky: unsupported opcode decoded
MemTimeout_1b  out  1  sticky: access abandoned on timeout
InstrCount  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (async, Reset_n_1b = 0): state FETCH, wait counter 0, InstrCount 0, both sticky flags 0. All control outputs 0 except the FETCH defaults below. Reset mid-access abandons the access immediately.
- Any control output not listed for a state is 0.
- State encodings and outputs:
  - FETCH (0): MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite and PCWrite = 1 only in the cycle MemReady_1b = 1. Next state is DECODE on MemReady; otherwise stay.
  - DECODE (1): ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by opcode: 000000 -> EXEC; 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 001000 -> ADDIEX; any other -> FETCH with IllegalOp_1b set.
  - MEMADR (2): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: MEMRD if opcode is 100011, else MEMWR.
  - MEMRD (3): MemRead = 1, IorD = 1. Wait for MemReady, then MEMWB.
  - MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0. Next: FETCH.
  - MEMWR (5): MemWrite = 1, IorD = 1. Wait for MemReady, then FETCH.
  - EXEC (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next: ALUWB.
  - ALUWB (7): RegDst = 1, RegWrite = 1. Next: FETCH.
  - BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Next: FETCH.
  - ADDIEX (9): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: ADDIWB.
  - ADDIWB (10): RegWrite = 1, RegDst = 0. Next: FETCH.
  - Encodings 11–15 are unreachable; if entered, go to FETCH.
- Opcode_6b is sampled every cycle and must stay stable from DECODE until the instruction retires.
- Wait counter: cleared on entry to FETCH, MEMRD or MEMWR. Increments each cycle in those states while MemReady_1b = 0.
  - When it reaches MEM_TIMEOUT with MemReady still 0: set MemTimeout_1b, deassert requests, go to FETCH next cycle. A timeout in FETCH restarts FETCH.
  - MemReady = 1 in the same cycle the count reaches MEM_TIMEOUT counts as success; no timeout.
- InstrCount increments by 1 on each retiring transition to FETCH: MEMWB, MEMWR-with-ready, ALUWB, BRANCH (taken or not), ADDIWB.
  - No increment on illegal opcode or timeout.
  - Wraps 2^CNT_W-1 -> 0.
- Latency with zero memory wait: R-type 4, addi 4, beq 3, sw 4, lw 5 cycles.

Optional Feature:
JUMP_EN
- Defined: opcode 000010 in DECODE goes to JUMP (11): PCWrite = 1, PCSource = 10, then FETCH; the jump counts as retired.
- Undefined: 000010 is illegal (IllegalOp set, FETCH, no count) and encoding 11 is unreachable.

Test Plan:
- Reset held low for 3 cycles, MemReady = 1 -> State_4b = 0, InstrCount = 0, flags 0. Assert reset mid-MEMRD -> state 0 asynchronously.
- MemReady tied 1; opcode 000000 -> states 0,1,6,7,0; RegDst = 1 and RegWrite = 1 only in state 7; InstrCount = 1. Repeat with opcode 001000 -> states 0,1,9,10,0.
- lw (100011) with MemReady delayed 2 cycles in FETCH and 3 in MEMRD -> 0,0,0,1,2,3,3,3,3,4,0 (11 cycles); IRWrite pulses once; InstrCount += 1.
- beq (000100) with Zero = 1 then Zero = 0 -> PCEn = 1 in state 8 only when Zero = 1; InstrCount += 2 total.
- sw with MemReady held 0, MEM_TIMEOUT = 15 -> after 15 cycles in state 5, MemTimeout_1b = 1, state 0, InstrCount unchanged.
- Opcode 000010: without JUMP_EN -> IllegalOp_1b = 1, state 0 after DECODE. With JUMP_EN -> state 11, PCWrite = 1, PCSource = 10, InstrCount += 1.
